ppi_port: RTL and testbench
===========================

# ppi_port

Parametrised 8255A-style peripheral port: one WIDTH-bit port with an output latch, an input latch, direction control and the Mode 1 strobed handshake (STB/IBF for input, OBF/ACK for output) with interrupt generation. It sits between the CPU-side register decode and the chip-level pad ring. Tristate is resolved at top level from `pad_out`/`pad_oe`, so the block itself is fully synchronous and has no inout ports. Three instances (ports A, B, C-upper/lower split externally) form the PPI.

## Interface
- `WIDTH`, 8, port data width (≥1)
- `clk`  input  1  system clock, all state on rising edge
- `rst`  input  1  synchronous, active-high reset
- `mode_wr`  input  1  one-cycle strobe: load `mode_in`
- `mode_in`  input  2  00 = Mode 0 output, 01 = Mode 0 input, 10 = Mode 1 strobed input, 11 = Mode 1 strobed output
- `inte`  input  1  interrupt enable (level, sampled every cycle)
- `wr_en`  input  1  CPU write strobe, one cycle
- `wr_data`  input  WIDTH  CPU write data
- `rd_en`  input  1  CPU read strobe, one cycle
- `rd_data`  output  WIDTH  CPU read data (registered)
- `pad_in`  input  WIDTH  pad input data
- `pad_out`  output  WIDTH  output latch to pads
- `pad_oe`  output  WIDTH  per-bit output enable (all ones or all zeros)
- `stb_n`  input  1  peripheral strobe, active low, asynchronous
- `ack_n`  input  1  peripheral acknowledge, active low, asynchronous
- `ibf`  output  1  input buffer full
- `obf_n`  output  1  output buffer full, active low
- `intr`  output  1  interrupt request
- `ovr`  output  1  sticky overrun flag

## Operation
- Reset: mode = 01, output latch = 0, input latch = 0, `rd_data` = 0, `pad_oe` = 0, `ibf` = 0, `obf_n` = 1, `intr` = 0, `ovr` = 0, synchroniser flops = 1.
- `mode_wr`: mode <= `mode_in`, output latch <= 0, `ibf` <= 0, `obf_n` <= 1, `intr` <= 0, `ovr` <= 0. This takes priority over every other event in the same cycle.
- `pad_oe` = all ones in modes 00 and 11, all zeros in 01 and 10. `pad_out` = output latch always.
- `wr_en` loads the output latch in every mode. In mode 11 it also sets `obf_n` <= 0 and `intr` <= 0.
- `stb_n` and `ack_n` each pass through a 2-flop synchroniser plus a previous-value flop. A fall or rise is detected when the synchronised and previous values differ.
- Mode 10, `stb_n` fall: input latch <= `pad_in`, `ibf` <= 1. If `ibf` was already 1 and no `rd_en` occurs in the same cycle, `ovr` <= 1.
- Mode 10, `stb_n` rise: `intr` <= 1 if `inte`.
- Mode 10, `rd_en`: `rd_data` <= input latch, `ibf` <= 0, `intr` <= 0.
- Mode 11, `ack_n` fall: `obf_n` <= 1.
- Mode 11, `ack_n` rise: `intr` <= 1 if `inte`.
- `rd_en` in modes 00/11: `rd_data` <= output latch. In mode 01: `rd_data` <= `pad_in`, unlatched.
- `rd_data` holds its value when `rd_en` is 0.
- `inte` low forces `intr` <= 0 on the next edge. Strobe and ack edges are ignored in modes 00/01.
- Simultaneous events:
  - `stb_n` fall + `rd_en`: read returns the old latch, then the new capture wins, leaving `ibf` = 1 and `ovr` unchanged.
  - `stb_n` rise + `rd_en`: `intr` set wins.
  - `wr_en` + `ack_n` fall: `obf_n` = 0 wins.
  - `wr_en` + `ack_n` rise: `intr` = 1 wins.

## Timing
- `stb_n`/`ack_n` first sampled low (or high) at edge k: resulting state change is visible after edge k+2.
- The input latch captures `pad_in` at that edge k+2. The peripheral must hold `pad_in` stable for at least 3 cycles after asserting `stb_n`. Minimum strobe/ack pulse is 3 cycles.
- `wr_en` at edge k: `pad_out`, `obf_n` and `intr` update after edge k.
- `rd_en` at edge k: `rd_data`, `ibf` and `intr` update after edge k, giving 1-cycle read latency.
- `mode_wr` at edge k: all outputs take their mode-entry values after edge k. Synchroniser contents are preserved.
- `rst` mid-handshake aborts the handshake; all outputs return to reset values after that edge.

## Test plan
- Reset then idle: `pad_oe`=00, `obf_n`=1, `ibf`=0, `intr`=0. Mode 01 with `pad_in`=5A, `rd_en` → `rd_data`=5A one cycle later.
- Mode 00: `wr_en` with A5 → `pad_out`=A5 and `pad_oe`=FF next cycle. `rd_en` → `rd_data`=A5.
- Mode 10, `inte`=1, `pad_in`=3C, `stb_n` low 4 cycles then high:
  - `ibf`=1 two edges after the fall, and `intr`=1 two edges after the rise.
  - `rd_en` → `rd_data`=3C, `ibf`=0, `intr`=0.
- Mode 10: two strobes with no read in between (C3 then 7E) → `ovr`=1, input latch=7E. A subsequent `mode_wr` clears `ovr`.
- Mode 11, `inte`=1: `wr_en` 81 → `obf_n`=0.
  - `ack_n` fall → `obf_n`=1 after 2 edges. `ack_n` rise → `intr`=1.
  - Next `wr_en` → `intr`=0. Repeat with `inte`=0 → `intr` stays 0.
- Simultaneous and reset cases:
  - `wr_en` in the same cycle as the synchronised `ack_n` fall → `obf_n`=0.
  - Assert `rst` while `ibf`=1 and `intr`=1 → all outputs at reset values after one edge.

Source files
------------

// File: rtl/ppi_port.sv
// ppi_port: one 8255A-style port with output/input latches, direction control
// and Mode 1 strobed handshake (STB/IBF input, OBF/ACK output) with interrupt.
module ppi_port #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_wr,
   input  logic [1:0]       mode_in,
   input  logic             inte,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   input  logic [WIDTH-1:0] pad_in,
   output logic [WIDTH-1:0] pad_out,
   output logic [WIDTH-1:0] pad_oe,
   input  logic             stb_n,
   input  logic             ack_n,
   output logic             ibf,
   output logic             obf_n,
   output logic             intr,
   output logic             ovr
);

   typedef enum logic [1:0] {
      ModeOut    = 2'b00,
      ModeIn     = 2'b01,
      ModeStbIn  = 2'b10,
      ModeStbOut = 2'b11
   } mode_e;

   mode_e            mode_q, mode_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] in_q, in_d;
   logic [WIDTH-1:0] rd_q, rd_d;
   logic             ibf_q, ibf_d;
   logic             obf_n_q, obf_n_d;
   logic             intr_q, intr_d;
   logic             ovr_q, ovr_d;

   // Synchroniser stage 1, stage 2 and previous-value flop per handshake line
   logic stb_s1_q, stb_s2_q, stb_prev_q;
   logic ack_s1_q, ack_s2_q, ack_prev_q;
   logic stb_fall, stb_rise, ack_fall, ack_rise;

   assign stb_fall = stb_prev_q & ~stb_s2_q;
   assign stb_rise = ~stb_prev_q & stb_s2_q;
   assign ack_fall = ack_prev_q & ~ack_s2_q;
   assign ack_rise = ~ack_prev_q & ack_s2_q;

   assign rd_data = rd_q;
   assign pad_out = out_q;
   assign pad_oe  = {WIDTH{(mode_q == ModeOut) || (mode_q == ModeStbOut)}};
   assign ibf     = ibf_q;
   assign obf_n   = obf_n_q;
   assign intr    = intr_q;
   assign ovr     = ovr_q;

   // Next-state: statement order encodes which simultaneous event wins
   always_comb begin
      mode_d  = mode_q;
      out_d   = out_q;
      in_d    = in_q;
      rd_d    = rd_q;
      ibf_d   = ibf_q;
      obf_n_d = obf_n_q;
      intr_d  = intr_q;
      ovr_d   = ovr_q;
      if (wr_en) out_d = wr_data;
      unique case (mode_q)
         ModeOut: if (rd_en) rd_d = out_q;
         ModeIn:  if (rd_en) rd_d = pad_in;
         ModeStbIn: begin
            if (rd_en) begin
               rd_d   = in_q;
               ibf_d  = 1'b0;
               intr_d = 1'b0;
            end
            // A capture in the same cycle as a read refills the buffer
            if (stb_fall) begin
               in_d  = pad_in;
               ibf_d = 1'b1;
               if (ibf_q && !rd_en) ovr_d = 1'b1;
            end
            if (stb_rise && inte) intr_d = 1'b1;
         end
         ModeStbOut: begin
            if (rd_en) rd_d = out_q;
            if (ack_fall) obf_n_d = 1'b1;
            if (wr_en) begin
               obf_n_d = 1'b0;
               intr_d  = 1'b0;
            end
            if (ack_rise && inte) intr_d = 1'b1;
         end
         default: ;
      endcase
      if (!inte) intr_d = 1'b0;
      if (mode_wr) begin
         mode_d  = mode_e'(mode_in);
         out_d   = '0;
         in_d    = in_q;
         rd_d    = rd_q;
         ibf_d   = 1'b0;
         obf_n_d = 1'b1;
         intr_d  = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // State registers and handshake synchronisers
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= ModeIn;
         out_q      <= '0;
         in_q       <= '0;
         rd_q       <= '0;
         ibf_q      <= 1'b0;
         obf_n_q    <= 1'b1;
         intr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         stb_s1_q   <= 1'b1;
         stb_s2_q   <= 1'b1;
         stb_prev_q <= 1'b1;
         ack_s1_q   <= 1'b1;
         ack_s2_q   <= 1'b1;
         ack_prev_q <= 1'b1;
      end else begin
         mode_q     <= mode_d;
         out_q      <= out_d;
         in_q       <= in_d;
         rd_q       <= rd_d;
         ibf_q      <= ibf_d;
         obf_n_q    <= obf_n_d;
         intr_q     <= intr_d;
         ovr_q      <= ovr_d;
         stb_s1_q   <= stb_n;
         stb_s2_q   <= stb_s1_q;
         stb_prev_q <= stb_s2_q;
         ack_s1_q   <= ack_n;
         ack_s2_q   <= ack_s1_q;
         ack_prev_q <= ack_s2_q;
      end
   end

endmodule

// File: tb/tb_ppi_port.sv
// tb_ppi_port: scenario tasks with randomized data against a port-level model.
module tb_ppi_port;

   logic       clk = 1'b0;
   logic       rst, mode_wr, inte, wr_en, rd_en, stb_n, ack_n;
   logic [1:0] mode_in;
   logic [7:0] wr_data, rd_data, pad_in, pad_out, pad_oe;
   logic       ibf, obf_n, intr, ovr;

   int checks = 0;
   int failures = 0;

   // Model: architectural state of the port as seen by CPU and peripheral
   logic [1:0] exp_mode;
   logic [7:0] exp_out, exp_in, exp_rd;
   logic       exp_ibf, exp_obf_n, exp_intr, exp_ovr;

   ppi_port #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .mode_wr(mode_wr), .mode_in(mode_in), .inte(inte),
      .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
      .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .stb_n(stb_n), .ack_n(ack_n),
      .ibf(ibf), .obf_n(obf_n), .intr(intr), .ovr(ovr)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      exp_mode = 2'b01; exp_out = 8'h00; exp_in = 8'h00; exp_rd = 8'h00;
      exp_ibf = 1'b0; exp_obf_n = 1'b1; exp_intr = 1'b0; exp_ovr = 1'b0;
   endtask

   task automatic set_mode(input logic [1:0] m);
      mode_in = m; mode_wr = 1'b1;
      tick;
      mode_wr = 1'b0;
      exp_mode = m; exp_out = 8'h00; exp_ibf = 1'b0; exp_obf_n = 1'b1;
      exp_intr = 1'b0; exp_ovr = 1'b0;
   endtask

   task automatic do_read;
      rd_en = 1'b1;
      tick;
      rd_en = 1'b0;
      case (exp_mode)
         2'b01: exp_rd = pad_in;
         2'b10: begin exp_rd = exp_in; exp_ibf = 1'b0; exp_intr = 1'b0; end
         default: exp_rd = exp_out;
      endcase
      if (!inte) exp_intr = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] d);
      wr_en = 1'b1; wr_data = d;
      tick;
      wr_en = 1'b0;
      exp_out = d;
      if (exp_mode == 2'b11) begin exp_obf_n = 1'b0; exp_intr = 1'b0; end
      if (!inte) exp_intr = 1'b0;
   endtask

   // Strobe held low 4 cycles; optional CPU read on the capture / rise edges
   task automatic stb_pulse(input logic [7:0] d, input bit rd_fall, input bit rd_rise);
      pad_in = d; stb_n = 1'b0;
      tick; tick;
      checks++;
      if (ibf !== exp_ibf) begin
         failures++; $display("FAIL stb_early_ibf: got %b exp %b", ibf, exp_ibf);
      end
      rd_en = rd_fall;
      tick;
      rd_en = 1'b0;
      if (rd_fall) begin exp_rd = exp_in; exp_intr = 1'b0; end
      else if (exp_ibf) exp_ovr = 1'b1;
      exp_in = d; exp_ibf = 1'b1;
      if (!inte) exp_intr = 1'b0;
      pad_in = 8'($urandom);
      checks++;
      if (ibf !== exp_ibf) begin
         failures++; $display("FAIL stb_capture_ibf: got %b exp %b", ibf, exp_ibf);
      end
      tick;
      stb_n = 1'b1;
      tick; tick;
      checks++;
      if (intr !== exp_intr) begin
         failures++; $display("FAIL stb_early_intr: got %b exp %b", intr, exp_intr);
      end
      rd_en = rd_rise;
      tick;
      rd_en = 1'b0;
      if (rd_rise) begin exp_rd = exp_in; exp_ibf = 1'b0; end
      exp_intr = inte;
      checks++;
      if (intr !== exp_intr) begin
         failures++; $display("FAIL stb_rise_intr: got %b exp %b", intr, exp_intr);
      end
   endtask

   // Ack held low 4 cycles; optional CPU write on the fall / rise edges
   task automatic ack_pulse(input bit wr_fall, input bit wr_rise);
      logic [7:0] d;
      ack_n = 1'b0;
      tick; tick;
      checks++;
      if (obf_n !== exp_obf_n) begin
         failures++; $display("FAIL ack_early_obf: got %b exp %b", obf_n, exp_obf_n);
      end
      d = 8'($urandom);
      wr_en = wr_fall; wr_data = d;
      tick;
      wr_en = 1'b0;
      exp_obf_n = 1'b1;
      if (wr_fall) begin exp_out = d; exp_obf_n = 1'b0; exp_intr = 1'b0; end
      if (!inte) exp_intr = 1'b0;
      checks++;
      if (obf_n !== exp_obf_n || pad_out !== exp_out) begin
         failures++;
         $display("FAIL ack_fall: got obf_n=%b pad_out=%h exp %b %h", obf_n, pad_out, exp_obf_n,
                  exp_out);
      end
      tick;
      ack_n = 1'b1;
      tick; tick;
      checks++;
      if (intr !== exp_intr) begin
         failures++; $display("FAIL ack_early_intr: got %b exp %b", intr, exp_intr);
      end
      d = 8'($urandom);
      wr_en = wr_rise; wr_data = d;
      tick;
      wr_en = 1'b0;
      if (wr_rise) begin exp_out = d; exp_obf_n = 1'b0; end
      exp_intr = inte;
      checks++;
      if (intr !== exp_intr || obf_n !== exp_obf_n) begin
         failures++;
         $display("FAIL ack_rise: got intr=%b obf_n=%b exp %b %b", intr, obf_n, exp_intr,
                  exp_obf_n);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick; tick;
      rst = 1'b0;
      model_reset;
      checks++;
      if ({pad_oe, pad_out, rd_data} !== 24'h0) begin
         failures++;
         $display("FAIL reset_data: got oe=%h out=%h rd=%h exp 00", pad_oe, pad_out, rd_data);
      end
      checks++;
      if ({ibf, obf_n, intr, ovr} !== 4'b0100) begin
         failures++; $display("FAIL reset_flags: got %b exp 0100", {ibf, obf_n, intr, ovr});
      end
   endtask

   task automatic test_mode0_in;
      set_mode(2'b01);
      checks++;
      if (pad_oe !== 8'h00) begin
         failures++; $display("FAIL in_oe: got %h exp 00", pad_oe);
      end
      for (int i = 0; i < 4; i++) begin
         pad_in = (i == 0) ? 8'h5A : 8'($urandom);
         do_read;
         checks++;
         if (rd_data !== exp_rd) begin
            failures++; $display("FAIL in_read: got %h exp %h", rd_data, exp_rd);
         end
      end
      pad_in = ~pad_in;
      tick;
      checks++;
      if (rd_data !== exp_rd) begin
         failures++; $display("FAIL rd_hold: got %h exp %h", rd_data, exp_rd);
      end
   endtask

   task automatic test_mode0_out;
      set_mode(2'b00);
      checks++;
      if (pad_oe !== 8'hFF || pad_out !== 8'h00) begin
         failures++; $display("FAIL out_entry: got oe=%h out=%h exp FF 00", pad_oe, pad_out);
      end
      for (int i = 0; i < 4; i++) begin
         do_write((i == 0) ? 8'hA5 : 8'($urandom));
         checks++;
         if (pad_out !== exp_out) begin
            failures++; $display("FAIL out_write: got %h exp %h", pad_out, exp_out);
         end
         do_read;
         checks++;
         if (rd_data !== exp_rd) begin
            failures++; $display("FAIL out_read: got %h exp %h", rd_data, exp_rd);
         end
      end
   endtask

   task automatic test_strobed_in;
      inte = 1'b1;
      set_mode(2'b10);
      for (int i = 0; i < 3; i++) begin
         stb_pulse((i == 0) ? 8'h3C : 8'($urandom), 1'b0, 1'b0);
         do_read;
         checks++;
         if (rd_data !== exp_rd || ibf !== exp_ibf || intr !== exp_intr || ovr !== exp_ovr) begin
            failures++;
            $display("FAIL sin_read: got rd=%h ibf=%b intr=%b ovr=%b exp %h %b %b %b", rd_data,
                     ibf, intr, ovr, exp_rd, exp_ibf, exp_intr, exp_ovr);
         end
      end
      stb_pulse(8'($urandom), 1'b0, 1'b0);
      inte = 1'b0;
      tick;
      exp_intr = 1'b0;
      checks++;
      if (intr !== exp_intr) begin
         failures++; $display("FAIL inte_low: got %b exp %b", intr, exp_intr);
      end
      inte = 1'b1;
      do_read;
   endtask

   task automatic test_overrun;
      inte = 1'b1;
      set_mode(2'b10);
      stb_pulse(8'hC3, 1'b0, 1'b0);
      stb_pulse(8'h7E, 1'b0, 1'b0);
      do_read;
      checks++;
      if (ovr !== exp_ovr || rd_data !== exp_rd) begin
         failures++;
         $display("FAIL overrun: got ovr=%b rd=%h exp %b %h", ovr, rd_data, exp_ovr, exp_rd);
      end
      set_mode(2'b10);
      checks++;
      if (ovr !== exp_ovr || ibf !== exp_ibf) begin
         failures++; $display("FAIL ovr_clear: got ovr=%b ibf=%b exp %b %b", ovr, ibf, exp_ovr,
                              exp_ibf);
      end
   endtask

   task automatic test_strobed_out;
      for (int pass = 0; pass < 2; pass++) begin
         inte = (pass == 0);
         set_mode(2'b11);
         checks++;
         if (pad_oe !== 8'hFF || obf_n !== 1'b1) begin
            failures++; $display("FAIL sout_entry: got oe=%h obf_n=%b exp FF 1", pad_oe, obf_n);
         end
         do_write(8'($urandom));
         checks++;
         if (obf_n !== exp_obf_n || pad_out !== exp_out) begin
            failures++; $display("FAIL sout_write: got obf_n=%b out=%h exp %b %h", obf_n,
                                 pad_out, exp_obf_n, exp_out);
         end
         ack_pulse(1'b0, 1'b0);
         do_read;
         checks++;
         if (rd_data !== exp_rd) begin
            failures++; $display("FAIL sout_read: got %h exp %h", rd_data, exp_rd);
         end
         do_write(8'($urandom));
         checks++;
         if (intr !== exp_intr || obf_n !== exp_obf_n) begin
            failures++; $display("FAIL sout_rewrite: got intr=%b obf_n=%b exp %b %b", intr,
                                 obf_n, exp_intr, exp_obf_n);
         end
      end
   endtask

   task automatic test_simultaneous;
      inte = 1'b1;
      set_mode(2'b11);
      do_write(8'($urandom));
      ack_pulse(1'b1, 1'b0);
      ack_pulse(1'b0, 1'b1);
      set_mode(2'b10);
      stb_pulse(8'($urandom), 1'b0, 1'b0);
      stb_pulse(8'($urandom), 1'b1, 1'b0);
      checks++;
      if (rd_data !== exp_rd || ibf !== exp_ibf || ovr !== exp_ovr) begin
         failures++; $display("FAIL fall_read: got rd=%h ibf=%b ovr=%b exp %h %b %b", rd_data,
                              ibf, ovr, exp_rd, exp_ibf, exp_ovr);
      end
      stb_pulse(8'($urandom), 1'b0, 1'b1);
      checks++;
      if (rd_data !== exp_rd || ibf !== exp_ibf || ovr !== exp_ovr) begin
         failures++; $display("FAIL rise_read: got rd=%h ibf=%b ovr=%b exp %h %b %b", rd_data,
                              ibf, ovr, exp_rd, exp_ibf, exp_ovr);
      end
   endtask

   task automatic test_rst_mid;
      inte = 1'b1;
      set_mode(2'b10);
      stb_pulse(8'($urandom), 1'b0, 1'b0);
      checks++;
      if (ibf !== 1'b1 || intr !== 1'b1) begin
         failures++; $display("FAIL pre_rst: got ibf=%b intr=%b exp 1 1", ibf, intr);
      end
      stb_n = 1'b0;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0; stb_n = 1'b1;
      model_reset;
      checks++;
      if ({pad_oe, pad_out, rd_data} !== 24'h0 || {ibf, obf_n, intr, ovr} !== 4'b0100) begin
         failures++; $display("FAIL mid_rst: got oe=%h out=%h rd=%h flags=%b exp 00 00 00 0100",
                              pad_oe, pad_out, rd_data, {ibf, obf_n, intr, ovr});
      end
      tick; tick; tick;
      checks++;
      if (ibf !== exp_ibf) begin
         failures++; $display("FAIL post_rst_ibf: got %b exp %b", ibf, exp_ibf);
      end
   endtask

   initial begin
      rst = 1'b1; mode_wr = 1'b0; mode_in = 2'b01; inte = 1'b0; wr_en = 1'b0;
      wr_data = 8'h00; rd_en = 1'b0; pad_in = 8'h00; stb_n = 1'b1; ack_n = 1'b1;
      model_reset;
      test_reset;
      test_mode0_in;
      test_mode0_out;
      test_strobed_in;
      test_overrun;
      test_strobed_out;
      test_simultaneous;
      test_rst_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
